pe_weight_loader: RTL and testbench

Writes all kernel weights and biases of one incha-style PE before inference. Consumes a packed 16-bit word stream from the DMA/host side through a valid/ready handshake and drives the PE's `weight_wr_data`/`weight_wr_addr`/`weight_wr_en` port. It is the initiator for the typed-address weight write protocol (type, channel, position).

---
 rtl/pe_wload_pkg.sv | 29 ++
 rtl/pe_wload_addr_gen.sv | 77 +++++++
 rtl/pe_weight_loader.sv | 204 ++++++++++++++++++++
 tb/tb_pe_weight_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_wload_pkg.sv
// pe_wload_pkg: shared definitions for the PE weight loader.
//   - wload_state_e : loader FSM states (StCheck only with PE_WLOAD_CHECKSUM_EN)
//   - Addr*Msb/Lsb  : field positions inside the 32-bit weight write address
//   - AddrType*Dflt : default type-field values for kernel and bias writes
// Configuration macro: PE_WLOAD_CHECKSUM_EN (adds the trailer/check state).
package pe_wload_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StKernel,
        StBias,
`ifdef PE_WLOAD_CHECKSUM_EN
        StCheck,
`endif
        StDone
    } wload_state_e;

    // Address layout: {type[31:24], channel[23:16], position[15:8], 8'h00}
    localparam int unsigned AddrTypeMsb = 31;
    localparam int unsigned AddrTypeLsb = 24;
    localparam int unsigned AddrChMsb   = 23;
    localparam int unsigned AddrChLsb   = 16;
    localparam int unsigned AddrPosMsb  = 15;
    localparam int unsigned AddrPosLsb  = 8;

    localparam logic [7:0] AddrTypeKernelDflt = 8'h00;
    localparam logic [7:0] AddrTypeBiasDflt   = 8'h01;

endpackage

// File: rtl/pe_wload_addr_gen.sv
// pe_wload_addr_gen: channel/position counters and packed write address.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear_i       : zero both counters (new load)
//   kernel_adv_i  : step position, wrapping into the next channel
//   bias_adv_i    : step channel, position held at 0
//   bias_sel_i    : select bias type field and force position 0 in addr_o
//   pos_last_o    : position is the last kernel word of a channel
//   ch_last_o     : channel is the last output channel
//   addr_o        : packed address for the current counters
// WORDS_PER_CH must be <= 256 so the position fits the 8-bit field.
module pe_wload_addr_gen
    import pe_wload_pkg::*;
#(
    parameter int unsigned OUT_CHANNEL      = 4,
    parameter int unsigned WORDS_PER_CH     = 18,
    parameter logic [7:0]  ADDR_TYPE_KERNEL = AddrTypeKernelDflt,
    parameter logic [7:0]  ADDR_TYPE_BIAS   = AddrTypeBiasDflt
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        kernel_adv_i,
    input  logic        bias_adv_i,
    input  logic        bias_sel_i,
    output logic        pos_last_o,
    output logic        ch_last_o,
    output logic [31:0] addr_o
);

    localparam logic [7:0] PosMax = 8'(WORDS_PER_CH - 1);
    localparam logic [7:0] ChMax  = 8'(OUT_CHANNEL - 1);

    logic [7:0] ch_q, ch_d;
    logic [7:0] pos_q, pos_d;

    assign pos_last_o = (pos_q == PosMax);
    assign ch_last_o  = (ch_q == ChMax);

    always_comb begin
        ch_d  = ch_q;
        pos_d = pos_q;
        if (clear_i) begin
            ch_d  = 8'd0;
            pos_d = 8'd0;
        end else if (kernel_adv_i) begin
            if (pos_last_o) begin
                pos_d = 8'd0;
                // Last kernel word of the last channel rewinds for the bias pass.
                ch_d  = ch_last_o ? 8'd0 : ch_q + 8'd1;
            end else begin
                pos_d = pos_q + 8'd1;
            end
        end else if (bias_adv_i) begin
            pos_d = 8'd0;
            ch_d  = ch_last_o ? 8'd0 : ch_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q  <= 8'd0;
            pos_q <= 8'd0;
        end else begin
            ch_q  <= ch_d;
            pos_q <= pos_d;
        end
    end

    always_comb begin
        addr_o = 32'd0;
        addr_o[AddrTypeMsb:AddrTypeLsb] = bias_sel_i ? ADDR_TYPE_BIAS : ADDR_TYPE_KERNEL;
        addr_o[AddrChMsb:AddrChLsb]     = ch_q;
        addr_o[AddrPosMsb:AddrPosLsb]   = bias_sel_i ? 8'd0 : pos_q;
    end

endmodule

// File: rtl/pe_weight_loader.sv
// pe_weight_loader: streams kernel weights then biases into one PE's weight port.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle pulse, begins a load (ignored unless idle)
//   s_data/s_valid : input word stream; s_ready high while a load consumes words
//   weight_wr_*    : registered write port, one write per accepted data word
//   busy           : load in progress
//   done           : one-cycle pulse on load completion
//   checksum_err   : trailer mismatch (sticky until next start)
// Configuration macro: PE_WLOAD_CHECKSUM_EN. When defined, one trailer word
// holding the 16-bit wrapping sum of all data words follows the biases and is
// compared; otherwise no trailer is consumed and checksum_err is tied 0.
module pe_weight_loader
    import pe_wload_pkg::*;
#(
    parameter int unsigned IN_CHANNEL       = 2,
    parameter int unsigned OUT_CHANNEL      = 4,
    parameter int unsigned KERNEL_0         = 3,
    parameter int unsigned KERNEL_1         = 3,
    parameter logic [7:0]  ADDR_TYPE_KERNEL = AddrTypeKernelDflt,
    parameter logic [7:0]  ADDR_TYPE_BIAS   = AddrTypeBiasDflt
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] weight_wr_data,
    output logic [31:0] weight_wr_addr,
    output logic        weight_wr_en,
    output logic        busy,
    output logic        done,
    output logic        checksum_err
);

    localparam int unsigned WORDS_PER_CH = KERNEL_0 * KERNEL_1 * IN_CHANNEL;

    wload_state_e state_q, state_d;

    logic        s_ready_q, s_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;

    logic        accept;
    logic        cnt_clear, kernel_adv, bias_adv;
    logic        pos_last, ch_last;
    logic [31:0] gen_addr;

`ifdef PE_WLOAD_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic        err_q, err_d;
`endif

    assign accept = s_valid & s_ready_q;

    pe_wload_addr_gen #(
        .OUT_CHANNEL      (OUT_CHANNEL),
        .WORDS_PER_CH     (WORDS_PER_CH),
        .ADDR_TYPE_KERNEL (ADDR_TYPE_KERNEL),
        .ADDR_TYPE_BIAS   (ADDR_TYPE_BIAS)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (cnt_clear),
        .kernel_adv_i (kernel_adv),
        .bias_adv_i   (bias_adv),
        .bias_sel_i   (state_q == StBias),
        .pos_last_o   (pos_last),
        .ch_last_o    (ch_last),
        .addr_o       (gen_addr)
    );

    always_comb begin
        state_d    = state_q;
        cnt_clear  = 1'b0;
        kernel_adv = 1'b0;
        bias_adv   = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef PE_WLOAD_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StKernel;
                    cnt_clear = 1'b1;
`ifdef PE_WLOAD_CHECKSUM_EN
                    sum_d     = 16'd0;
                    err_d     = 1'b0;
`endif
                end
            end
            StKernel: begin
                if (accept) begin
                    kernel_adv = 1'b1;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = gen_addr;
                    wr_data_d  = {8'h00, s_data[7:0]};
`ifdef PE_WLOAD_CHECKSUM_EN
                    sum_d      = sum_q + s_data;
`endif
                    if (ch_last && pos_last) begin
                        state_d = StBias;
                    end
                end
            end
            StBias: begin
                if (accept) begin
                    bias_adv  = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = gen_addr;
                    wr_data_d = s_data;
`ifdef PE_WLOAD_CHECKSUM_EN
                    sum_d     = sum_q + s_data;
                    if (ch_last) begin
                        state_d = StCheck;
                    end
`else
                    if (ch_last) begin
                        state_d = StDone;
                    end
`endif
                end
            end
`ifdef PE_WLOAD_CHECKSUM_EN
            StCheck: begin
                // Trailer word: compared only, never written to the PE.
                if (accept) begin
                    err_d   = (s_data != sum_q);
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Output flags are registered from the next state so they line up
        // with the state they describe.
        s_ready_d = (state_d == StKernel) || (state_d == StBias)
`ifdef PE_WLOAD_CHECKSUM_EN
                    || (state_d == StCheck)
`endif
                    ;
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 32'd0;
            wr_data_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef PE_WLOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign checksum_err = err_q;
`else
    assign checksum_err = 1'b0;
`endif

    assign s_ready        = s_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign weight_wr_en   = wr_en_q;
    assign weight_wr_addr = wr_addr_q;
    assign weight_wr_data = wr_data_q;

endmodule

// File: tb/tb_pe_weight_loader.sv
// tb_pe_weight_loader: directed bench for pe_weight_loader (default parameters).
// A monitor compares every write against an address/data model indexed by the
// write number; a driver runs full loads, stalled loads, idle offers and a
// mid-load reset. Trailer checks are compiled in with PE_WLOAD_CHECKSUM_EN.
module tb_pe_weight_loader;

    localparam int NWORDS = 76;  // 4 * (18 + 1)
`ifdef PE_WLOAD_CHECKSUM_EN
    localparam int NLOAD = NWORDS + 1;
`else
    localparam int NLOAD = NWORDS;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] weight_wr_data;
    logic [31:0] weight_wr_addr;
    logic        weight_wr_en;
    logic        busy;
    logic        done;
    logic        checksum_err;

    int n_pass  = 0;
    int n_total = 0;
    int wr_cnt  = 0;
    logic acc_last = 1'b0;

    always #5 clk = ~clk;

    pe_weight_loader u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .weight_wr_data (weight_wr_data),
        .weight_wr_addr (weight_wr_addr),
        .weight_wr_en   (weight_wr_en),
        .busy           (busy),
        .done           (done),
        .checksum_err   (checksum_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] word_of(input int i);
        if (i == 5 || i == 73) return 16'hABCD;
        return 16'(i * 16'h0135 + 16'h1200);
    endfunction

    function automatic logic [31:0] exp_addr(input int k);
        if (k < 72) return {8'h00, 8'(k / 18), 8'(k % 18), 8'h00};
        return {8'h01, 8'(k - 72), 16'h0000};
    endfunction

    function automatic logic [15:0] exp_data(input int k);
        logic [15:0] w;
        w = word_of(k);
        if (k < 72) return {8'h00, w[7:0]};
        return w;
    endfunction

    // Monitor: one write per accept, in model order.
    always @(negedge clk) begin
        if (start && !busy) wr_cnt = 0;
        check("wr_en_follows_accept", {31'd0, weight_wr_en}, {31'd0, acc_last});
        if (weight_wr_en) begin
            check("wr_addr", weight_wr_addr, exp_addr(wr_cnt));
            check("wr_data", {16'd0, weight_wr_data}, {16'd0, exp_data(wr_cnt)});
            if (wr_cnt == 0)  check("first_kernel_addr", weight_wr_addr, 32'h0000_0000);
            if (wr_cnt == 71) check("last_kernel_addr", weight_wr_addr, 32'h0003_1100);
            if (wr_cnt == 5)  check("kernel_abcd", {16'd0, weight_wr_data}, 32'h0000_00CD);
            if (wr_cnt == 73) check("bias_abcd", {16'd0, weight_wr_data}, 32'h0000_ABCD);
            wr_cnt++;
        end
        if (done) check("writes_at_done", wr_cnt, NWORDS);
    end

    // Runs one load. abort_at >= 0 resets the DUT after that many accepts;
    // start_at >= 0 re-pulses start while busy at that word.
    task automatic run_load(input bit gaps, input int abort_at, input int start_at,
                            input logic [15:0] trailer);
        int  i;
        int  cyc;
        bit  acc;
        s_valid = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("ready_after_start", {31'd0, s_ready}, 32'd1);
`ifdef PE_WLOAD_CHECKSUM_EN
        check("err_cleared_by_start", {31'd0, checksum_err}, 32'd0);
`endif
        i   = 0;
        cyc = 0;
        while (i < NLOAD && cyc < 2000) begin
            if (i == abort_at) begin
                s_valid  = 1'b0;
                acc_last = 1'b0;
                rst_n    = 1'b0;
                #1;
                check("rst_wr_en", {31'd0, weight_wr_en}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_ready", {31'd0, s_ready}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                check("rst_addr", weight_wr_addr, 32'd0);
                check("rst_data", {16'd0, weight_wr_data}, 32'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = (i < NWORDS) ? word_of(i) : trailer;
            start   = (i == start_at);
            acc     = s_valid && s_ready;
            @(posedge clk); #1;
            acc_last = acc && (i < NWORDS);
            if (acc) i++;
            cyc++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        check("load_completed", i, NLOAD);
        check("done_after_last", {31'd0, done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        acc_last = 1'b0;
        check("busy_dropped", {31'd0, busy}, 32'd0);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("ready_dropped", {31'd0, s_ready}, 32'd0);
    endtask

    initial begin
        logic [15:0] sum;
        sum = 16'd0;
        for (int k = 0; k < NWORDS; k++) sum = sum + word_of(k);

        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'd0;
        #12;
        check("reset_ready", {31'd0, s_ready}, 32'd0);
        check("reset_wr_en", {31'd0, weight_wr_en}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, checksum_err}, 32'd0);
        check("reset_addr", weight_wr_addr, 32'd0);
        check("reset_data", {16'd0, weight_wr_data}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full load, continuous valid, correct trailer when present.
        run_load(1'b0, -1, -1, sum);
`ifdef PE_WLOAD_CHECKSUM_EN
        check("good_trailer", {31'd0, checksum_err}, 32'd0);
`endif

        // Words offered while idle are not consumed.
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_data  = 16'h5555;
            check("idle_not_ready", {31'd0, s_ready}, 32'd0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;

        // Random stalls plus a start pulse while busy; bad trailer when present.
        run_load(1'b1, -1, 40, sum + 16'd1);
`ifdef PE_WLOAD_CHECKSUM_EN
        check("bad_trailer", {31'd0, checksum_err}, 32'd1);
`endif

        // Reset after 30 words, then a clean load from address 0.
        run_load(1'b0, 30, -1, sum);
        run_load(1'b0, -1, -1, sum);
`ifdef PE_WLOAD_CHECKSUM_EN
        check("trailer_after_reset", {31'd0, checksum_err}, 32'd0);
`else
        check("err_tied_low", {31'd0, checksum_err}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
